regbank_access_sequencer: RTL and testbench

- Bus initiator for the single-port register bank (shared addr_bus, read_enable, write_enable and bidirectional data_bus).
- Accepts one "read rs, read rt, optionally write rd" request through a valid/ready handshake and serialises it into bank bus cycles.
- Returns both read operands through a valid/ready response channel.
- Sits between the datapath/decode stage and the bank; emulates a 2R/1W register file on a 1-port bank.

---
 rtl/regbank_pkg.sv | 15 +
 rtl/regbank_access_sequencer_if.sv | 34 +++
 rtl/regbank_tristate_driver.sv | 14 +
 rtl/regbank_access_sequencer.sv | 105 ++++++++++
 tb/tb_regbank_access_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the single-port register bank and its access sequencer.
package regbank_pkg;

    localparam int unsigned ADDR_BITS = 5;
    localparam int unsigned WORD_WIDE = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/regbank_access_sequencer_if.sv
// Request/response channel between the decode stage and the bank access sequencer.
interface regbank_access_sequencer_if
    import regbank_pkg::*;
#(
    parameter int unsigned addr_bits = ADDR_BITS,
    parameter int unsigned word_wide = WORD_WIDE
);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_re;
    logic                 req_we;
    logic [addr_bits-1:0] req_rs_addr;
    logic [addr_bits-1:0] req_rt_addr;
    logic [addr_bits-1:0] req_rd_addr;
    logic [word_wide-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [word_wide-1:0] rsp_rs_data;
    logic [word_wide-1:0] rsp_rt_data;

    modport master (
        output req_valid, req_re, req_we, req_rs_addr, req_rt_addr, req_rd_addr, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rs_data, rsp_rt_data
    );

    modport slave (
        input  req_valid, req_re, req_we, req_rs_addr, req_rt_addr, req_rd_addr, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rs_data, rsp_rt_data
    );

endinterface

// File: rtl/regbank_tristate_driver.sv
// Sole tri-state point on the shared bank data bus; also returns the resolved bus value.
module regbank_tristate_driver #(
    parameter int unsigned word_wide = 32
) (
    input  logic                 drive_enable,
    input  logic [word_wide-1:0] drive_data,
    inout  wire  [word_wide-1:0] bus,
    output logic [word_wide-1:0] bus_in
);

    assign bus    = drive_enable ? drive_data : {word_wide{1'bz}};
    assign bus_in = bus;

endmodule

// File: rtl/regbank_access_sequencer.sv
// Serialises a 2-read/1-write register request onto a single-port bank bus,
// giving 2R/1W register-file behaviour with reads always ahead of the write.
module regbank_access_sequencer
    import regbank_pkg::*;
#(
    parameter int unsigned addr_bits = ADDR_BITS,
    parameter int unsigned word_wide = WORD_WIDE
) (
    input  logic                      clock,
    input  logic                      reset,
    regbank_access_sequencer_if.slave req_if,
    output logic [addr_bits-1:0]      addr_bus,
    output logic                      read_enable,
    output logic                      write_enable,
    inout  wire  [word_wide-1:0]      data_bus
);

    state_e               state_q, state_d;
    logic                 we_q;
    logic [addr_bits-1:0] rs_q, rt_q, rd_q;
    logic [word_wide-1:0] wdata_q;
    logic [word_wide-1:0] rs_data_q, rt_data_q;
    logic [word_wide-1:0] bus_in;

    regbank_tristate_driver #(.word_wide(word_wide)) u_drv (
        .drive_enable (write_enable),
        .drive_data   (wdata_q),
        .bus          (data_bus),
        .bus_in       (bus_in)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state plus bus strobes decoded straight from the state register
    always_comb begin
        state_d      = state_q;
        addr_bus     = '0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    if (req_if.req_re)      state_d = ST_READ_A;
                    else if (req_if.req_we) state_d = ST_WRITE;
                    else                    state_d = ST_RESP;
                end
            end
            ST_READ_A: begin
                addr_bus    = rs_q;
                read_enable = 1'b1;
                state_d     = ST_READ_B;
            end
            ST_READ_B: begin
                addr_bus    = rt_q;
                read_enable = 1'b1;
                state_d     = we_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                addr_bus     = rd_q;
                write_enable = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (req_if.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch and read-data capture on the edge leaving each read state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            wdata_q   <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
        end else begin
            if (state_q == ST_IDLE && req_if.req_valid) begin
                we_q    <= req_if.req_we;
                rs_q    <= req_if.req_rs_addr;
                rt_q    <= req_if.req_rt_addr;
                rd_q    <= req_if.req_rd_addr;
                wdata_q <= req_if.req_wdata;
                if (!req_if.req_re) begin
                    rs_data_q <= '0;
                    rt_data_q <= '0;
                end
            end
            if (state_q == ST_READ_A) rs_data_q <= bus_in;
            if (state_q == ST_READ_B) rt_data_q <= bus_in;
        end
    end

    assign req_if.req_ready   = (state_q == ST_IDLE);
    assign req_if.rsp_valid   = (state_q == ST_RESP);
    assign req_if.rsp_rs_data = rs_data_q;
    assign req_if.rsp_rt_data = rt_data_q;

endmodule

// File: tb/tb_regbank_access_sequencer.sv
// Directed bench for regbank_access_sequencer with a behavioural single-port bank.
module tb_regbank_access_sequencer;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam logic [DW-1:0] PROBE = 32'h1248_0C30;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr_bus;
    logic          read_enable;
    logic          write_enable;
    wire  [DW-1:0] data_bus;

    logic [DW-1:0] mem [32];
    int total = 0;
    int bad   = 0;

    regbank_access_sequencer_if #(.addr_bits(AW), .word_wide(DW)) rif ();

    regbank_access_sequencer #(.addr_bits(AW), .word_wide(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_if       (rif),
        .addr_bus     (addr_bus),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .data_bus     (data_bus)
    );

    always #5 clock = ~clock;

    // Bank model drives read data; otherwise a probe pattern exposes any stray DUT drive
    assign data_bus = write_enable ? {DW{1'bz}} : (read_enable ? mem[addr_bus] : PROBE);

    always @(posedge clock) begin
        if (write_enable) mem[addr_bus] <= data_bus;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic re, input logic we, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic [AW-1:0] rd, input logic [DW-1:0] wd);
        rif.req_valid   = 1'b1;
        rif.req_re      = re;
        rif.req_we      = we;
        rif.req_rs_addr = rs;
        rif.req_rt_addr = rt;
        rif.req_rd_addr = rd;
        rif.req_wdata   = wd;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rif.req_valid   = 1'b0;
        rif.req_re      = 1'b0;
        rif.req_we      = 1'b0;
        rif.req_rs_addr = '0;
        rif.req_rt_addr = '0;
        rif.req_rd_addr = '0;
        rif.req_wdata   = '0;
        rif.rsp_ready   = 1'b1;

        step();
        step();
        chk("rst_re",    32'(read_enable), 32'd0);
        chk("rst_we",    32'(write_enable), 32'd0);
        chk("rst_addr",  32'(addr_bus), 32'd0);
        chk("rst_bus",   data_bus, PROBE);
        chk("rst_rspv",  32'(rif.rsp_valid), 32'd0);
        chk("rst_rs",    rif.rsp_rs_data, 32'd0);
        chk("rst_rt",    rif.rsp_rt_data, 32'd0);
        reset = 1'b0;
        step();
        chk("idle_ready", 32'(rif.req_ready), 32'd1);

        // Write-only request
        send(1'b0, 1'b1, 5'd7, 5'd9, 5'd5, 32'hDEAD_BEEF);
        step();
        rif.req_valid = 1'b0;
        chk("wo_we",     32'(write_enable), 32'd1);
        chk("wo_re",     32'(read_enable), 32'd0);
        chk("wo_addr",   32'(addr_bus), 32'd5);
        chk("wo_bus",    data_bus, 32'hDEAD_BEEF);
        chk("wo_ready",  32'(rif.req_ready), 32'd0);
        chk("wo_rspv0",  32'(rif.rsp_valid), 32'd0);
        step();
        chk("wo_rspv",   32'(rif.rsp_valid), 32'd1);
        chk("wo_we_off", 32'(write_enable), 32'd0);
        chk("wo_bus_z",  data_bus, PROBE);
        chk("wo_rs",     rif.rsp_rs_data, 32'd0);
        chk("wo_rt",     rif.rsp_rt_data, 32'd0);
        chk("wo_mem5",   mem[5], 32'hDEAD_BEEF);
        step();
        chk("wo_idle",   32'(rif.req_ready), 32'd1);

        // Dual read, rt = register 0
        send(1'b1, 1'b0, 5'd5, 5'd0, 5'd3, 32'h0);
        step();
        rif.req_valid = 1'b0;
        chk("dr_a_re",   32'(read_enable), 32'd1);
        chk("dr_a_addr", 32'(addr_bus), 32'd5);
        chk("dr_a_we",   32'(write_enable), 32'd0);
        step();
        chk("dr_b_re",   32'(read_enable), 32'd1);
        chk("dr_b_addr", 32'(addr_bus), 32'd0);
        step();
        chk("dr_rspv",   32'(rif.rsp_valid), 32'd1);
        chk("dr_re_off", 32'(read_enable), 32'd0);
        chk("dr_rs",     rif.rsp_rs_data, 32'hDEAD_BEEF);
        chk("dr_rt",     rif.rsp_rt_data, 32'd0);
        step();

        // Read-before-write hazard, then backpressure in RESP
        send(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 32'h1);
        step();
        rif.req_valid = 1'b0;
        step();
        step();
        chk("hz_we",     32'(write_enable), 32'd1);
        chk("hz_addr",   32'(addr_bus), 32'd5);
        chk("hz_bus",    data_bus, 32'h1);
        rif.rsp_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("bp_rspv",  32'(rif.rsp_valid), 32'd1);
            chk("bp_rs",    rif.rsp_rs_data, 32'hDEAD_BEEF);
            chk("bp_rt",    rif.rsp_rt_data, 32'hDEAD_BEEF);
            chk("bp_ready", 32'(rif.req_ready), 32'd0);
            chk("bp_en",    32'({read_enable, write_enable}), 32'd0);
            chk("bp_bus",   data_bus, PROBE);
            step();
        end
        rif.rsp_ready = 1'b1;
        step();
        chk("bp_idle",   32'(rif.req_ready), 32'd1);
        chk("bp_rspv0",  32'(rif.rsp_valid), 32'd0);

        // Read back register 5 on both ports
        send(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
        step();
        rif.req_valid = 1'b0;
        step();
        step();
        chk("rb_rs",     rif.rsp_rs_data, 32'h1);
        chk("rb_rt",     rif.rsp_rt_data, 32'h1);
        step();

        // Null request
        send(1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF);
        step();
        rif.req_valid = 1'b0;
        chk("nl_rspv",   32'(rif.rsp_valid), 32'd1);
        chk("nl_en",     32'({read_enable, write_enable}), 32'd0);
        chk("nl_rs",     rif.rsp_rs_data, 32'd0);
        chk("nl_rt",     rif.rsp_rt_data, 32'd0);
        step();

        // Asynchronous reset in the middle of WRITE
        send(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h55AA_55AA);
        step();
        rif.req_valid = 1'b0;
        chk("mr_we_pre", 32'(write_enable), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_we",     32'(write_enable), 32'd0);
        chk("mr_bus",    data_bus, PROBE);
        chk("mr_rspv",   32'(rif.rsp_valid), 32'd0);
        chk("mr_addr",   32'(addr_bus), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("mr_ready",  32'(rif.req_ready), 32'd1);
        chk("mr_rspv2",  32'(rif.rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
